// File: rtl/acc_core_param.sv
// acc_core_param: parametrised multi-cycle accumulator core.
// Each instruction is fetched in one cycle and executed in the next.
// Instruction memory is loaded through prog_*. Data memory can be read through dbg_*.
//
// Handshake: start is a one-cycle request that is accepted only in IDLE or HALTED.
// On the accepting edge, busy rises and execution begins at pc=0. While busy is high,
// start and prog_we are ignored. busy falls and halted rises on the edge that executes HALT.
module acc_core_param #(
    parameter int DATA_W   = 8,
    parameter int OPND_W   = 5,
    parameter int IM_DEPTH = 32,
    parameter int DM_DEPTH = 16,
    localparam int PC_W    = $clog2(IM_DEPTH),
    localparam int DM_AW   = $clog2(DM_DEPTH),
    localparam int IW      = 3 + OPND_W
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              start,
    input  logic              prog_we,
    input  logic [PC_W-1:0]   prog_addr,
    input  logic [IW-1:0]     prog_data,
    input  logic [DM_AW-1:0]  dbg_addr,
    output logic [DATA_W-1:0] dbg_data,
    output logic [DATA_W-1:0] acc,
    output logic [PC_W-1:0]   pc,
    output logic              busy,
    output logic              halted,
    output logic              zero,
    output logic              neg,
    output logic              ovf,
    output logic [1:0]        dbg_state
);

    typedef enum logic [1:0] {S_IDLE, S_FETCH, S_EXEC, S_HALTED} state_t;

    localparam logic [2:0] OP_HALT = 3'd0;
    localparam logic [2:0] OP_LDD  = 3'd1;
    localparam logic [2:0] OP_LDM  = 3'd2;
    localparam logic [2:0] OP_ST   = 3'd3;
    localparam logic [2:0] OP_ADD  = 3'd4;
    localparam logic [2:0] OP_XOR  = 3'd5;
    localparam logic [2:0] OP_JMP  = 3'd6;
    localparam logic [2:0] OP_SUB  = 3'd7;   // BRZ when operand MSB is set

    logic [IW-1:0]     im [IM_DEPTH];
    logic [DATA_W-1:0] dm [DM_DEPTH];
    state_t            state;
    logic [IW-1:0]     ir;

    logic [2:0]        opcode;
    logic [OPND_W-1:0] operand;
    logic [DM_AW-1:0]  dm_a;
    logic [DATA_W-1:0] dm_rd;
    logic [DATA_W-1:0] imm;
    logic [DATA_W-1:0] sum;
    logic [DATA_W-1:0] diff;
    logic              add_ovf;
    logic              sub_ovf;
    logic [PC_W-1:0]   pc_inc;
    logic [PC_W-1:0]   target;
    logic              idle_like;

    assign opcode    = ir[IW-1 -: 3];
    assign operand   = ir[OPND_W-1:0];
    assign dm_a      = operand[DM_AW-1:0];
    assign dm_rd     = dm[dm_a];
    assign imm       = DATA_W'($signed(operand));
    assign sum       = acc + dm_rd;
    assign diff      = acc - dm_rd;
    // Signed overflow: the result sign disagrees with what the operand signs allow.
    assign add_ovf   = (acc[DATA_W-1] == dm_rd[DATA_W-1]) && (sum[DATA_W-1] != acc[DATA_W-1]);
    assign sub_ovf   = (acc[DATA_W-1] != dm_rd[DATA_W-1]) && (diff[DATA_W-1] != acc[DATA_W-1]);
    assign pc_inc    = pc + PC_W'(1);
    assign target    = operand[PC_W-1:0];
    assign idle_like = (state == S_IDLE) || (state == S_HALTED);

    assign zero      = (acc == '0);
    assign neg       = acc[DATA_W-1];
    assign dbg_data  = dm[dbg_addr];
    assign dbg_state = state;

    // Instruction memory write port. It is open only while the core is not executing.
    always_ff @(posedge clock) begin
        if (prog_we && idle_like)
            im[prog_addr] <= prog_data;
    end

    // Core state machine. Fetch and execute each take one cycle.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state  <= S_IDLE;
            pc     <= '0;
            acc    <= '0;
            ovf    <= 1'b0;
            busy   <= 1'b0;
            halted <= 1'b0;
            ir     <= '0;
            for (int i = 0; i < DM_DEPTH; i++)
                dm[i] <= '0;
        end else begin
            case (state)
                S_IDLE, S_HALTED: begin
                    if (start) begin
                        pc     <= '0;
                        ovf    <= 1'b0;
                        busy   <= 1'b1;
                        halted <= 1'b0;
                        state  <= S_FETCH;
                    end
                end
                S_FETCH: begin
                    ir    <= im[pc];
                    state <= S_EXEC;
                end
                S_EXEC: begin
                    state <= S_FETCH;
                    pc    <= pc_inc;
                    case (opcode)
                        OP_HALT: begin
                            state  <= S_HALTED;
                            pc     <= pc;
                            busy   <= 1'b0;
                            halted <= 1'b1;
                        end
                        OP_LDD: acc <= imm;
                        OP_LDM: acc <= dm_rd;
                        OP_ST:  dm[dm_a] <= acc;
                        OP_ADD: begin
                            acc <= sum;
                            ovf <= add_ovf;
                        end
                        OP_XOR: acc <= acc ^ dm_rd;
                        OP_JMP: pc <= target;
                        OP_SUB: begin
                            if (operand[OPND_W-1]) begin
                                if (zero)
                                    pc <= target;
                            end else begin
                                acc <= diff;
                                ovf <= sub_ovf;
                            end
                        end
                        default: ;
                    endcase
                end
                default: state <= S_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_acc_core_param.sv
// tb_acc_core_param: directed programs plus random straight-line programs.
// The results are checked against an integer ISA interpreter.
module tb_acc_core_param;

    logic       clock = 1'b0;
    logic       reset = 1'b0;
    logic       start = 1'b0;
    logic       prog_we = 1'b0;
    logic [4:0] prog_addr = '0;
    logic [7:0] prog_data = '0;
    logic [3:0] dbg_addr = '0;
    logic [7:0] dbg_data;
    logic [7:0] acc;
    logic [4:0] pc;
    logic       busy;
    logic       halted;
    logic       zero;
    logic       neg;
    logic       ovf;
    logic [1:0] dbg_state;

    acc_core_param dut (
        .clock(clock), .reset(reset), .start(start), .prog_we(prog_we),
        .prog_addr(prog_addr), .prog_data(prog_data), .dbg_addr(dbg_addr),
        .dbg_data(dbg_data), .acc(acc), .pc(pc), .busy(busy), .halted(halted),
        .zero(zero), .neg(neg), .ovf(ovf), .dbg_state(dbg_state)
    );

    // clock / reset
    always #5 clock = ~clock;

    int n_cmp = 0;
    int n_bad = 0;

    // reference model state
    logic [7:0] im_m [32];
    logic [7:0] dm_m [16];
    logic [7:0] acc_m;
    logic       ovf_m;
    logic [4:0] pc_m;
    int         steps_m;
    logic [7:0] exp_q [$];

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
        n_cmp++;
        assert (obs === exp_v) else begin
            n_bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp_v);
        end
    endtask

    function automatic logic [7:0] enc(input int op, input int opd);
        logic [2:0] o;
        logic [4:0] d;
        o = 3'(op);
        d = 5'(opd);
        return {o, d};
    endfunction

    task automatic model_reset();
        acc_m = '0;
        ovf_m = 1'b0;
        pc_m  = '0;
        for (int i = 0; i < 16; i++) dm_m[i] = '0;
    endtask

    // ISA interpreter: signed integer arithmetic, range-checked for overflow.
    task automatic model_run();
        bit done;
        int op, opd, sopd, a, r;
        pc_m = '0;
        ovf_m = 1'b0;
        steps_m = 0;
        done = 0;
        while (!done && steps_m < 500) begin
            op   = int'(im_m[pc_m][7:5]);
            opd  = int'(im_m[pc_m][4:0]);
            sopd = (opd >= 16) ? opd - 32 : opd;
            a    = opd % 16;
            steps_m++;
            case (op)
                0: done = 1;
                1: acc_m = 8'(sopd);
                2: acc_m = dm_m[a];
                3: dm_m[a] = acc_m;
                4: begin
                    r = int'($signed(acc_m)) + int'($signed(dm_m[a]));
                    ovf_m = (r > 127) || (r < -128);
                    acc_m = 8'(r);
                end
                5: acc_m = acc_m ^ dm_m[a];
                default: ;
            endcase
            if (!done) begin
                if (op == 6)
                    pc_m = 5'(opd % 32);
                else if (op == 7 && opd >= 16)
                    pc_m = (acc_m == 0) ? 5'(opd % 32) : 5'((int'(pc_m) + 1) % 32);
                else begin
                    if (op == 7) begin
                        r = int'($signed(acc_m)) - int'($signed(dm_m[a]));
                        ovf_m = (r > 127) || (r < -128);
                        acc_m = 8'(r);
                    end
                    pc_m = 5'((int'(pc_m) + 1) % 32);
                end
            end
        end
    endtask

    // driver: write one instruction word (core idle)
    task automatic load(input int addr, input logic [7:0] w);
        @(negedge clock);
        prog_we = 1'b1;
        prog_addr = 5'(addr);
        prog_data = w;
        @(negedge clock);
        prog_we = 1'b0;
        im_m[addr] = w;
    endtask

    // driver: pulse start, optionally disturb with start+prog_we at cycle dist_cyc, wait for halt
    task automatic run(input string tag, input int dist_cyc, input int dist_addr, input logic [7:0] dist_word);
        int cyc;
        @(negedge clock);
        start = 1'b1;
        @(negedge clock);
        start = 1'b0;
        cyc = 0;
        check({tag, "_busy"}, busy, 1);
        while (!halted && cyc < 2000) begin
            if (cyc == dist_cyc) begin
                start = 1'b1;
                prog_we = 1'b1;
                prog_addr = 5'(dist_addr);
                prog_data = dist_word;
            end
            @(negedge clock);
            start = 1'b0;
            prog_we = 1'b0;
            cyc++;
        end
        check({tag, "_halted"}, halted, 1);
        model_run();
        check({tag, "_cycles"}, cyc, 2 * steps_m);
    endtask

    // scoreboard: compare architectural state and all of DM against the model
    task automatic check_all(input string tag);
        check({tag, "_acc"}, acc, acc_m);
        check({tag, "_ovf"}, ovf, ovf_m);
        check({tag, "_zero"}, zero, acc_m == 0);
        check({tag, "_neg"}, neg, acc_m[7]);
        check({tag, "_pc"}, pc, pc_m);
        check({tag, "_busy0"}, busy, 0);
        for (int i = 0; i < 16; i++) exp_q.push_back(dm_m[i]);
        for (int i = 0; i < 16; i++) begin
            dbg_addr = 4'(i);
            #1;
            check({tag, "_dm"}, dbg_data, exp_q.pop_front());
        end
    endtask

    initial begin
        int len;
        int op;
        int opd;
        int ops [6] = '{1, 2, 3, 4, 5, 7};

        // reset state
        model_reset();
        repeat (2) @(negedge clock);
        check("rst_acc", acc, 0);
        check("rst_pc", pc, 0);
        check("rst_busy", busy, 0);
        check("rst_halted", halted, 0);
        check("rst_ovf", ovf, 0);
        check("rst_zero", zero, 1);
        reset = 1'b1;

        // 1: X/Y/Z/A/B/T program, 18 instructions + HALT
        load(0, enc(1, 7));    load(1, enc(3, 0));   load(2, enc(1, -2));
        load(3, enc(3, 1));    load(4, enc(2, 0));   load(5, enc(4, 1));
        load(6, enc(3, 2));    load(7, enc(1, 3));   load(8, enc(3, 4));
        load(9, enc(1, 6));    load(10, enc(3, 5));  load(11, enc(2, 4));
        load(12, enc(5, 5));   load(13, enc(3, 6));  load(14, enc(2, 4));
        load(15, enc(7, 0));   load(16, enc(3, 3));  load(17, enc(2, 3));
        load(18, enc(0, 0));
        run("p1", -1, 0, 0);
        check("p1_steps38", 2 * steps_m, 38);
        check("p1_acc_fc", acc, 8'hFC);
        check("p1_neg", neg, 1);
        dbg_addr = 4'd3; #1; check("p1_dm3", dbg_data, 8'hFC);
        dbg_addr = 4'd2; #1; check("p1_dm2", dbg_data, 8'h05);
        check_all("p1");

        // 2: build 127 in DM[0], then 127+1 overflows; then -128-127 wraps to 1
        load(0, enc(1, 15));  load(1, enc(3, 0));  load(2, enc(4, 0));
        load(3, enc(3, 0));   load(4, enc(4, 0));  load(5, enc(3, 0));
        load(6, enc(4, 0));   load(7, enc(3, 0));  load(8, enc(1, 7));
        load(9, enc(4, 0));   load(10, enc(3, 0)); load(11, enc(1, 1));
        load(12, enc(4, 0));  load(13, enc(0, 0));
        run("ovf_add", -1, 0, 0);
        check("ovf_add_acc80", acc, 8'h80);
        check("ovf_add_flag", ovf, 1);
        check_all("ovf_add");
        load(0, enc(7, 0));   load(1, enc(0, 0));
        run("ovf_sub", -1, 0, 0);
        check("ovf_sub_acc1", acc, 8'h01);
        check("ovf_sub_flag", ovf, 1);
        check_all("ovf_sub");

        // 3: countdown loop with BRZ exit to word 16
        load(0, enc(1, 1));   load(1, enc(3, 1));  load(2, enc(1, 3));
        load(3, enc(7, 1));   load(4, enc(7, 16)); load(5, enc(6, 3));
        load(16, enc(0, 0));
        run("loop", -1, 0, 0);
        check("loop_zero", zero, 1);
        check("loop_pc16", pc, 16);
        check_all("loop");

        // 4: BRZ to word 31 (LD_D 7), pc wraps to 0, BRZ not taken, HALT at 1
        load(0, enc(7, 31));  load(1, enc(0, 0));  load(31, enc(1, 7));
        run("wrap", -1, 0, 0);
        check("wrap_acc7", acc, 8'h07);
        check_all("wrap");

        // 5: reset asserted during EXEC of ST
        load(0, enc(1, 5));   load(1, enc(3, 2));  load(2, enc(0, 0));
        @(negedge clock);
        start = 1'b1;
        @(negedge clock);
        start = 1'b0;
        repeat (3) @(negedge clock);
        check("mid_acc5", acc, 8'h05);
        reset = 1'b0;
        #1;
        model_reset();
        @(negedge clock);
        check("mid_rst_halted", halted, 0);
        check_all("mid_rst");
        reset = 1'b1;
        run("rerun", -1, 0, 0);
        check("rerun_acc5", acc, 8'h05);
        check_all("rerun");

        // 6: prog_we/start while busy ignored; prog_we while halted takes effect
        load(0, enc(1, 3));   load(1, enc(3, 4));  load(2, enc(1, 2));
        load(3, enc(0, 0));
        run("busy_we", 3, 2, enc(1, -1));
        check("busy_we_acc2", acc, 8'h02);
        check_all("busy_we");
        load(2, enc(1, -1));
        run("halt_we", -1, 0, 0);
        check("halt_we_accff", acc, 8'hFF);
        check_all("halt_we");

        // random straight-line programs
        for (int t = 0; t < 6; t++) begin
            len = $urandom_range(4, 12);
            for (int i = 0; i < len; i++) begin
                op  = ops[$urandom_range(0, 5)];
                opd = $urandom_range(0, 31);
                if (op == 7) opd = opd % 16;
                load(i, enc(op, opd));
            end
            load(len, enc(0, 0));
            run("rnd", -1, 0, 0);
            check_all("rnd");
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
